// File: rtl/sdram_mrs_model.sv
// Behavioural SDRAM model with a programmable mode register (CL 2/3, BL 1/2/4/8
// with wrapping), per-bank open-row tracking, write byte masks and sticky
// protocol-violation flags. Commands are sampled on the falling clock edge.
module sdram_mrs_model #(
    parameter int W_BANKSEL = 2,
    parameter int W_ADDR    = 13,
    parameter int W_DATA    = 16,
    parameter int W_ROW     = 13,
    parameter int W_COL     = 10,
    parameter int W_DEPTH   = 16,
    parameter int T_RCD     = 2
) (
    input  logic                   clk_sys,
    input  logic                   rst_n_sys,
    input  logic [W_BANKSEL-1:0]   sdram_ba,
    input  logic [W_ADDR-1:0]      sdram_a,
    input  logic [W_DATA/8-1:0]    sdram_dqm,
    input  logic [W_DATA-1:0]      sdram_dq_o,
    output logic [W_DATA-1:0]      sdram_dq_i,
    output logic                   sdram_dq_i_valid,
    input  logic                   sdram_clke,
    input  logic                   sdram_cs_n,
    input  logic                   sdram_ras_n,
    input  logic                   sdram_cas_n,
    input  logic                   sdram_we_n,
    output logic [3:0]             err_sticky
);

    localparam int NB    = 1 << W_BANKSEL;
    localparam int W_DQM = W_DATA / 8;
    localparam int W_RCD = $clog2(T_RCD + 1);
    localparam logic [W_RCD-1:0] RCD_LOAD = W_RCD'(T_RCD - 1);

    typedef enum logic [3:0] {
        CMD_MRS = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_BST = 4'b0110,
        CMD_NOP = 4'b0111
    } cmd_e;

    cmd_e                  cmd;
    logic [NB-1:0]         open_q, open_d;
    logic [W_ROW-1:0]      row_q [NB];
    logic [W_ROW-1:0]      row_d [NB];
    logic [W_RCD-1:0]      rcd_q [NB];
    logic [W_RCD-1:0]      rcd_d [NB];
    logic [1:0]            cl_q, cl_d;
    logic [3:0]            bl_q, bl_d;
    logic                  bact_q, bact_d;
    logic                  bwr_q, bwr_d;
    logic [3:0]            bbeat_q, bbeat_d;
    logic [3:0]            blen_q, blen_d;
    logic [W_COL-1:0]      bcol_q, bcol_d;
    logic [W_ROW-1:0]      brow_q, brow_d;
    logic [W_BANKSEL-1:0]  bba_q, bba_d;
    logic [W_DATA-1:0]     dq_pipe_q [3];
    logic [W_DATA-1:0]     dq_pipe_d [3];
    logic [2:0]            vld_pipe_q, vld_pipe_d;
    logic [3:0]            err_q, err_d;

    logic                  beat_do, beat_wr, fetch, cont, mem_we;
    logic [W_ROW-1:0]      beat_row;
    logic [W_BANKSEL-1:0]  beat_ba;
    logic [W_COL-1:0]      beat_col;
    logic [W_DEPTH-1:0]    mem_addr;
    logic [W_DATA-1:0]     mem [0:(1<<W_DEPTH)-1];

    // Column of beat k: wraps inside the BL-aligned block containing the start column.
    function automatic logic [W_COL-1:0] wrap_col(input logic [W_COL-1:0] start,
                                                  input logic [3:0] k,
                                                  input logic [3:0] bl);
        logic [W_COL-1:0] mask;
        mask = W_COL'(bl) - W_COL'(1);
        return (start & ~mask) | ((start + W_COL'(k)) & mask);
    endfunction

    // Storage index is {row, bank, col} truncated to the stored depth.
    function automatic logic [W_DEPTH-1:0] full_addr(input logic [W_ROW-1:0] r,
                                                     input logic [W_BANKSEL-1:0] b,
                                                     input logic [W_COL-1:0] c);
        return W_DEPTH'({r, b, c});
    endfunction

    // Command decode; a deselected device or a stopped clock reads as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (sdram_clke && !sdram_cs_n)
            cmd = cmd_e'({1'b0, sdram_ras_n, sdram_cas_n, sdram_we_n});
    end

    // Next state: bank bookkeeping, mode register, burst sequencing and read pipe.
    always_comb begin
        open_d   = open_q;
        row_d    = row_q;
        rcd_d    = rcd_q;
        cl_d     = cl_q;
        bl_d     = bl_q;
        bact_d   = bact_q;
        bwr_d    = bwr_q;
        bbeat_d  = bbeat_q;
        blen_d   = blen_q;
        bcol_d   = bcol_q;
        brow_d   = brow_q;
        bba_d    = bba_q;
        err_d    = err_q;
        beat_do  = 1'b0;
        beat_wr  = 1'b0;
        beat_row = brow_q;
        beat_ba  = bba_q;
        beat_col = bcol_q;
        cont     = 1'b1;

        for (int b = 0; b < NB; b++)
            if (rcd_q[b] != '0) rcd_d[b] = rcd_q[b] - W_RCD'(1);

        case (cmd)
            CMD_ACT: begin
                if (open_q[sdram_ba]) err_d[1] = 1'b1;
                open_d[sdram_ba] = 1'b1;
                row_d[sdram_ba]  = sdram_a[W_ROW-1:0];
                rcd_d[sdram_ba]  = RCD_LOAD;
            end
            CMD_PRE: begin
                if (sdram_a[10]) open_d = '0;
                else             open_d[sdram_ba] = 1'b0;
                bact_d = 1'b0;
                cont   = 1'b0;
            end
            CMD_BST: begin
                bact_d = 1'b0;
                cont   = 1'b0;
            end
            CMD_REF: begin
                if (|open_q) err_d[3] = 1'b1;
            end
            CMD_MRS: begin
                if (|open_q) err_d[3] = 1'b1;
                case (sdram_a[2:0])
                    3'd0:    bl_d = 4'd1;
                    3'd1:    bl_d = 4'd2;
                    3'd2:    bl_d = 4'd4;
                    3'd3:    bl_d = 4'd8;
                    default: bl_d = bl_q;
                endcase
                case (sdram_a[6:4])
                    3'd2:    cl_d = 2'd2;
                    3'd3:    cl_d = 2'd3;
                    default: cl_d = cl_q;
                endcase
            end
            CMD_RD, CMD_WR: begin
                if (!open_q[sdram_ba])      err_d[0] = 1'b1;
                if (rcd_q[sdram_ba] != '0)  err_d[2] = 1'b1;
                beat_do  = 1'b1;
                beat_wr  = (cmd == CMD_WR);
                beat_row = row_q[sdram_ba];
                beat_ba  = sdram_ba;
                beat_col = sdram_a[W_COL-1:0];
                bact_d   = (bl_q != 4'd1);
                bwr_d    = (cmd == CMD_WR);
                bbeat_d  = 4'd1;
                blen_d   = bl_q;
                bcol_d   = sdram_a[W_COL-1:0];
                brow_d   = row_q[sdram_ba];
                bba_d    = sdram_ba;
                cont     = 1'b0;
            end
            default: ;
        endcase

        if (bact_q && cont) begin
            beat_do  = 1'b1;
            beat_wr  = bwr_q;
            beat_row = brow_q;
            beat_ba  = bba_q;
            beat_col = wrap_col(bcol_q, bbeat_q, blen_q);
            bbeat_d  = bbeat_q + 4'd1;
            if (bbeat_q + 4'd1 == blen_q) bact_d = 1'b0;
        end

        mem_addr = full_addr(beat_row, beat_ba, beat_col);
        mem_we   = beat_do && beat_wr && rst_n_sys;
        fetch    = beat_do && !beat_wr;

        dq_pipe_d[0] = fetch ? mem[mem_addr] : '0;
        dq_pipe_d[1] = dq_pipe_q[0];
        dq_pipe_d[2] = dq_pipe_q[1];
        vld_pipe_d   = {vld_pipe_q[1:0], fetch};
    end

    // Control and read-pipe state, cleared asynchronously by reset.
    always_ff @(negedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            open_q     <= '0;
            for (int b = 0; b < NB; b++) begin
                row_q[b] <= '0;
                rcd_q[b] <= '0;
            end
            cl_q       <= 2'd2;
            bl_q       <= 4'd8;
            bact_q     <= 1'b0;
            bwr_q      <= 1'b0;
            bbeat_q    <= '0;
            blen_q     <= '0;
            bcol_q     <= '0;
            brow_q     <= '0;
            bba_q      <= '0;
            for (int i = 0; i < 3; i++) dq_pipe_q[i] <= '0;
            vld_pipe_q <= '0;
            err_q      <= '0;
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            rcd_q      <= rcd_d;
            cl_q       <= cl_d;
            bl_q       <= bl_d;
            bact_q     <= bact_d;
            bwr_q      <= bwr_d;
            bbeat_q    <= bbeat_d;
            blen_q     <= blen_d;
            bcol_q     <= bcol_d;
            brow_q     <= brow_d;
            bba_q      <= bba_d;
            dq_pipe_q  <= dq_pipe_d;
            vld_pipe_q <= vld_pipe_d;
            err_q      <= err_d;
        end
    end

    // Byte-masked storage write; contents survive reset.
    always_ff @(negedge clk_sys) begin
        if (mem_we)
            for (int j = 0; j < W_DQM; j++)
                if (!sdram_dqm[j]) mem[mem_addr][8*j +: 8] <= sdram_dq_o[8*j +: 8];
    end

    // The live CL picks the tap of the read pipe that drives the pins.
    always_comb begin
        if (cl_q == 2'd3) begin
            sdram_dq_i       = dq_pipe_q[2];
            sdram_dq_i_valid = vld_pipe_q[2];
        end else begin
            sdram_dq_i       = dq_pipe_q[1];
            sdram_dq_i_valid = vld_pipe_q[1];
        end
    end

    assign err_sticky = err_q;

endmodule

// File: tb/tb_sdram_mrs_model.sv
// Self-checking bench for sdram_mrs_model: a reference memory plus a queue of
// expected read beats (data and sampling cycle) checked by a pin monitor.
module tb_sdram_mrs_model;

    localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010,
                           C_ACT = 4'b0011, C_WR  = 4'b0100, C_RD  = 4'b0101,
                           C_BST = 4'b0110, C_NOP = 4'b0111;

    logic        clk_sys = 1'b0;
    logic        rst_n_sys;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_o;
    logic [15:0] sdram_dq_i;
    logic        sdram_dq_i_valid;
    logic        sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [3:0]  err_sticky;

    typedef struct { logic [15:0] data; int cyc; } exp_t;
    exp_t        sb[$];
    logic [15:0] model [int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          nvalid  = 0;
    int          n0;

    sdram_mrs_model dut (
        .clk_sys(clk_sys), .rst_n_sys(rst_n_sys), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
        .sdram_dqm(sdram_dqm), .sdram_dq_o(sdram_dq_o), .sdram_dq_i(sdram_dq_i),
        .sdram_dq_i_valid(sdram_dq_i_valid), .sdram_clke(sdram_clke), .sdram_cs_n(sdram_cs_n),
        .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .err_sticky(err_sticky)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fa(input int row, input int ba, input int col);
        return ((row << 12) | (ba << 10) | col) & 32'hFFFF;
    endfunction

    function automatic int wcol(input int start, input int k, input int bl);
        int off;
        off = start % bl;
        return start - off + ((off + k) % bl);
    endfunction

    function automatic logic [15:0] mread(input int addr);
        if (model.exists(addr)) return model[addr];
        return 16'h0;
    endfunction

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] dq, input logic [1:0] m);
        @(posedge clk_sys); #1;
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba = ba; sdram_a = a; sdram_dq_o = dq; sdram_dqm = m;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 2'b11);
    endtask

    task automatic wr_burst(input int ba, input int row, input int col, input int bl,
                            input logic [15:0] d0, input int step,
                            input logic [1:0] m0, input logic [1:0] mrest);
        for (int k = 0; k < bl; k++) begin
            logic [15:0] d, v;
            logic [1:0]  m;
            int          ad;
            d = d0 + 16'(k * step);
            m = (k == 0) ? m0 : mrest;
            issue((k == 0) ? C_WR : C_NOP, 2'(ba), (k == 0) ? 13'(col) : 13'd0, d, m);
            ad = fa(row, ba, wcol(col, k, bl));
            v  = mread(ad);
            if (!m[0]) v[7:0]  = d[7:0];
            if (!m[1]) v[15:8] = d[15:8];
            model[ad] = v;
        end
    endtask

    task automatic rd_burst(input int ba, input int row, input int col, input int bl,
                            input int cl, input int nb);
        int   p;
        exp_t e;
        issue(C_RD, 2'(ba), 13'(col), 16'd0, 2'b11);
        p = cyc;
        for (int k = 0; k < nb; k++) begin
            e.data = mread(fa(row, ba, wcol(col, k, bl)));
            e.cyc  = p + cl + k;
            sb.push_back(e);
        end
    endtask

    // Pin monitor on the rising edge, half a cycle away from the model's active edge.
    always @(posedge clk_sys) begin
        exp_t e;
        cyc = cyc + 1;
        if (sdram_dq_i_valid) begin
            nvalid++;
            if (sb.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rd_data", sdram_dq_i, e.data);
                chk("rd_cycle", cyc, e.cyc);
            end
        end else begin
            chk("idle_dq_zero", sdram_dq_i, 32'd0);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("missing_beat", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        rst_n_sys = 1'b0;
        sdram_clke = 1'b1;
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
        sdram_ba = '0; sdram_a = '0; sdram_dq_o = '0; sdram_dqm = 2'b11;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_dq", sdram_dq_i, 32'd0);
        chk("rst_vld", sdram_dq_i_valid, 32'd0);
        chk("rst_err", err_sticky, 32'd0);
        rst_n_sys = 1'b1;

        // CL=2 BL=8, wrapped write then wrapped read
        issue(C_MRS, 2'd0, 13'h023, 16'd0, 2'b11);
        issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'b11);
        nops(1);
        wr_burst(1, 5, 10'h3FC, 8, 16'h1000, 1, 2'b00, 2'b00);
        wr_burst(1, 5, 10'h000, 8, 16'h2000, 1, 2'b00, 2'b00);
        n0 = nvalid;
        rd_burst(1, 5, 10'h3FC, 8, 2, 8);
        nops(12);
        chk("beats_cl2_bl8", nvalid - n0, 32'd8);

        // CL=3 BL=4
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b11);
        issue(C_MRS, 2'd0, 13'h032, 16'd0, 2'b11);
        issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'b11);
        nops(1);
        n0 = nvalid;
        rd_burst(1, 5, 10'h002, 4, 3, 4);
        nops(10);
        chk("beats_cl3_bl4", nvalid - n0, 32'd4);

        // byte mask: upper lane masked over 0xAAAA
        wr_burst(1, 5, 10'h010, 4, 16'hAAAA, 0, 2'b00, 2'b00);
        wr_burst(1, 5, 10'h010, 4, 16'h1234, 0, 2'b10, 2'b11);
        rd_burst(1, 5, 10'h010, 4, 3, 4);
        nops(10);
        chk("dqm_model", mread(fa(5, 1, 16)), 32'hAA34);

        // BST after third fetch
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b11);
        issue(C_MRS, 2'd0, 13'h023, 16'd0, 2'b11);
        issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'b11);
        nops(1);
        n0 = nvalid;
        rd_burst(1, 5, 10'h3F8, 8, 2, 3);
        nops(2);
        issue(C_BST, 2'd0, 13'd0, 16'd0, 2'b11);
        nops(12);
        chk("beats_after_bst", nvalid - n0, 32'd3);

        // sticky protocol errors
        chk("err_clean", err_sticky, 32'd0);
        issue(C_WR, 2'd2, 13'd0, 16'd0, 2'b11);
        issue(C_BST, 2'd0, 13'd0, 16'd0, 2'b11);
        chk("err_idle_bank", err_sticky, 32'h1);
        issue(C_ACT, 2'd3, 13'd1, 16'd0, 2'b11);
        issue(C_WR, 2'd3, 13'd0, 16'd0, 2'b11);
        issue(C_BST, 2'd0, 13'd0, 16'd0, 2'b11);
        chk("err_trcd", err_sticky, 32'h5);
        issue(C_ACT, 2'd1, 13'd7, 16'd0, 2'b11);
        nops(1);
        chk("err_act_open", err_sticky, 32'h7);
        issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b11);
        nops(1);
        chk("err_ref_open", err_sticky, 32'hF);
        nops(5);
        chk("err_hold", err_sticky, 32'hF);

        // reset mid-read
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b11);
        issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'b11);
        nops(1);
        rd_burst(1, 5, 10'h3FC, 8, 2, 1);
        nops(2);
        #2;
        rst_n_sys = 1'b0;
        #1;
        chk("midrst_dq", sdram_dq_i, 32'd0);
        chk("midrst_vld", sdram_dq_i_valid, 32'd0);
        chk("midrst_err", err_sticky, 32'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n_sys = 1'b1;

        // defaults CL=2 BL=8 after reset
        issue(C_ACT, 2'd1, 13'd5, 16'd0, 2'b11);
        nops(1);
        n0 = nvalid;
        rd_burst(1, 5, 10'h3FC, 8, 2, 8);
        nops(12);
        chk("beats_post_reset", nvalid - n0, 32'd8);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_mrs_model.md
# sdram_mrs_model

Parametrised SDRAM behavioural model for simulation benches. It replaces the fixed-CL/fixed-BL model with a mode-register-programmable device: CAS latency 2/3, burst length 1/2/4/8 with wrapping, per-bank open-row tracking, PRECHARGE/BURST TERMINATE/AUTO REFRESH, write byte masking, and sticky protocol-violation flags. It sits on the SDRAM pins of the controller under test in the top-level testbench. It uses only synthesisable constructs, but it is not intended for synthesis.

## Interface
Parameters:
- W_BANKSEL, 2, bank select width
- W_ADDR, 13, address bus width (A10 is the precharge-all bit)
- W_DATA, 16, DQ width; multiple of 8
- W_ROW, 13, row address width
- W_COL, 10, column address width
- W_DEPTH, 16, log2 of stored words; full address truncated to its LSBs
- T_RCD, 2, minimum clocks from ACTIVATE to READ/WRITE on the same bank

Ports:
- clk_sys  in  1  model clock; all commands are sampled on the negedge
- rst_n_sys  in  1  asynchronous active-low reset
- sdram_ba  in  W_BANKSEL  bank select
- sdram_a  in  W_ADDR  row/column/mode address
- sdram_dqm  in  W_DATA/8  byte masks (write data only)
- sdram_dq_o  in  W_DATA  write data from controller
- sdram_dq_i  out  W_DATA  read data to controller; zero when no beat is being returned
- sdram_dq_i_valid  out  1  high while sdram_dq_i carries a read beat
- sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command pins
- err_sticky  out  4  sticky violation flags: [0] RD/WR to idle bank, [1] ACTIVATE to an open bank, [2] tRCD violation, [3] command while not in idle-all-banks state that requires it (MRS/REFRESH)

## Operation
- Command = {cs_n,ras_n,cas_n,we_n}, decoded only when clke=1. Decodes: NOP 0111, ACT 0011, RD 0101, WR 0100, BST 0110, PRE 0010, REF 0001, MRS 0000. cs_n=1 is treated as NOP.
- Bank state per bank: idle/open, open row, and a tRCD down-counter loaded with T_RCD-1 on ACT.
- ACT: open the bank and latch the row. If the bank is already open, set err[1] and overwrite the row.
- PRE: close bank ba, or all banks if A10=1. Terminates any burst.
- REF and MRS: flag err[3] if any bank is open. REF is otherwise a NOP.
- MRS: A[2:0] sets BL (0→1, 1→2, 2→4, 3→8; other codes hold the old value). A[6:4] sets CL (2 or 3; other codes hold the old value). Sequential burst only; A[3] is ignored.
- Full address = {row, ba, col} truncated to W_DEPTH bits. Burst beat k uses col = (start & ~(BL-1)) | ((start+k) & (BL-1)), i.e. it wraps within the BL-aligned block.
- RD/WR to an idle bank: set err[0]; the burst proceeds using the stale row. RD/WR while that bank's tRCD counter is nonzero: set err[2]; the burst proceeds.
- WR: beat 0 is written on the command edge and beats 1..BL-1 on the following edges. Byte lane j is written only if dqm[j]=0.
- RD: beat data is fetched on the command edge and the following edges, then delayed through a CL-deep pipe.
- A new RD/WR truncates the current burst immediately. BST or PRE stops further fetches and writes. Beats already in the read pipe still emerge.
- Read pipe depth is selected by the live CL; changing CL via MRS mid-burst is not required to be meaningful.

## Timing
- Reset: sdram_dq_i=0, sdram_dq_i_valid=0, err_sticky=0, all banks idle, tRCD counters 0, CL=2, BL=8, no burst. Memory contents are not reset.
- Reset asserted mid-burst aborts it: no further writes, and the pipe is flushed to zero/invalid.
- RD sampled at negedge n: beat k is valid on sdram_dq_i from negedge n+CL-1+k until the next negedge. The controller samples it on the CL-th posedge after driving the command.
- ACT at negedge n: RD/WR is legal from negedge n+T_RCD onward.
- err bits set on the offending negedge and clear only on reset.

## Test plan
- MRS CL=2 BL=8; ACT row 5 bank 1; WR col 0x3FC data 0x1000..0x1007; RD col 0x3FC -> beats return in wrap order col 3FC,3FD,3FE,3FF,3F8..3FB with matching data, first beat after negedge n+1, valid high for 8 clocks.
- MRS CL=3 BL=4; RD col 2 -> data arrives one clock later than at CL=2, order 2,3,0,1, valid for 4 clocks.
- WR beat with dqm=2'b10 over existing 0xAAAA, data 0x1234 -> readback 0xAA34.
- RD BL=8, then BST after beat 2 is fetched -> exactly 3 valid beats, then dq_i=0.
- RD to idle bank -> err[0]=1. ACT then RD one clock later with T_RCD=2 -> err[2]=1. ACT to an open bank -> err[1]=1. Bits hold until rst_n_sys low.
- Assert rst_n_sys mid-read -> dq_i=0 and valid=0 immediately. After release, CL=2/BL=8 defaults apply.
